pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register, the generalised successor of the fixed MEM/WB register. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake, and adds a 2-entry skid buffer so throughput is one transfer per cycle under back-pressure. It also provides a synchronous flush, bubble masking of control bits, and a saturating stall counter. It is instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
PAYLOAD_W, 71, payload width; default = 2*`WORD_LEN + `REG_ADDR_LEN + 2 (the MEM/WB bundle).
KILL_MASK, 71'h0 with bits [70:69] set, payload bits forced to 0 whenever OUT_VALID=0 (write/read enables).
SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single entry with combinational IN_READY.
CNT_W, 16, stall counter width.

Ports:
CLK  in  1  clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
FLUSH  in  1  synchronous kill of all held entries.
IN_VALID  in  1  upstream has a payload.
IN_READY  out  1  stage can accept a payload this cycle.
IN_PAYLOAD  in  PAYLOAD_W  upstream payload.
OUT_VALID  out  1  OUT_PAYLOAD is valid.
OUT_READY  in  1  downstream accepts this cycle.
OUT_PAYLOAD  out  PAYLOAD_W  head payload; KILL_MASK bits are 0 when OUT_VALID=0.
OCCUPANCY  out  2  number of entries held (0..2; max 1 when SKID=0).
STALL_CNT  out  CNT_W  saturating count of cycles with OUT_VALID=1 and OUT_READY=0.

Behaviour:
- Reset (RESET_N=0, async): main_valid=0, skid_valid=0, payload registers=0, STALL_CNT=0, OCCUPANCY=0, OUT_VALID=0, OUT_PAYLOAD=0. IN_READY=1 from reset (SKID=1); reset mid-transfer discards all data immediately.
- Handshakes: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY. Payload must not be consumed unless its fire condition is true.
- Latency: 1 cycle. A payload accepted at edge N is visible on OUT_* after edge N.
- SKID=1, storage: main (head) and skid (overflow). IN_READY = ~skid_valid, registered with no combinational path from OUT_READY.
  - Empty, in_fire: write main.
  - Main full, out_fire and in_fire: main <= IN_PAYLOAD.
  - Main full, no out_fire, in_fire: write skid, so OCCUPANCY=2 and IN_READY drops next cycle.
  - Both full, out_fire: main <= skid, skid_valid=0. IN_READY cannot be 1 in this state, so no in_fire.
  - Order is strictly FIFO; a payload never overtakes or duplicates.
- SKID=0: single main entry. IN_READY = OUT_READY | ~main_valid (combinational). The skid register is not built.
- FLUSH (sampled at edge): clears main_valid and skid_valid. Any in_fire in the same cycle is discarded, so FLUSH has priority over IN_VALID. out_fire in the flush cycle still completes as a normal transfer. Payload registers are not cleared; masking covers them.
- Bubble masking: OUT_PAYLOAD = main_payload & ~KILL_MASK when main_valid=0, so downstream stages ignoring valid never see a stale write-enable.
- STALL_CNT: increments on each cycle with OUT_VALID & ~OUT_READY and saturates at 2^CNT_W-1 (no wrap). Cleared only by reset; FLUSH does not clear it.
- OCCUPANCY = main_valid + skid_valid, registered-derived with no combinational input dependence.
- Invariant: skid_valid=1 implies main_valid=1 (assertion in the bench).

Decomposition:
- Shared defines: `WORD_LEN, `REG_ADDR_LEN (existing) plus the new MEM/WB payload field offsets (`MWB_WB_EN_BIT=70, `MWB_MEM_RD_BIT=69, ALU result [68:37], mem operand [36:5], dest [4:0]) and the default KILL_MASK constant.
- One sub-module, pipe_slot: a valid bit plus payload register with async active-low reset, load and clear. It is instantiated as main and, under generate when SKID=1, as skid.

Test Plan:
- Reset then streaming: OUT_READY=1, inputs 0x11..0x15 on 5 consecutive cycles -> outputs 0x11..0x15 one cycle later, IN_READY held 1, OCCUPANCY≤1, STALL_CNT=0.
- Back-pressure: send A=0xA, B=0xB with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0 the next cycle, OUT_PAYLOAD=0xA held. Release OUT_READY -> A then B out in order, with no loss or duplicate.
- Flush collision: OCCUPANCY=2 while asserting FLUSH with IN_VALID=1 (0xC) -> next cycle OUT_VALID=0, OCCUPANCY=0, 0xC never appears, OUT_PAYLOAD bits [70:69]=0.
- Stall counter saturation: CNT_W=4, OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT reaches 15 and stays 15.
- Async reset mid-operation: drop RESET_N between edges with OCCUPANCY=2 -> OUT_VALID, OCCUPANCY, STALL_CNT go to 0 before the next edge; after release, IN_READY=1.
- SKID=0 build: OUT_READY toggling 1,0,1,0 with continuous IN_VALID -> IN_READY follows OUT_READY in the same cycle when full, and OCCUPANCY never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared pipeline-register definitions: MEM/WB bundle layout and the default bubble kill mask.
package pipe_stage_skid_reg_pkg;

  localparam int unsigned WORD_LEN       = 32;
  localparam int unsigned REG_ADDR_LEN   = 5;
  localparam int unsigned MWB_PAYLOAD_W  = 2 * WORD_LEN + REG_ADDR_LEN + 2;

  localparam int unsigned MWB_WB_EN_BIT  = 70;
  localparam int unsigned MWB_MEM_RD_BIT = 69;
  localparam int unsigned MWB_ALU_LSB    = 37;
  localparam int unsigned MWB_MEM_LSB    = 5;
  localparam int unsigned MWB_DEST_LSB   = 0;

  typedef struct packed {
    logic                    wb_en;
    logic                    mem_rd;
    logic [WORD_LEN-1:0]     alu_res;
    logic [WORD_LEN-1:0]     mem_data;
    logic [REG_ADDR_LEN-1:0] dest;
  } mwb_payload_t;

  // Enables that must never be seen asserted on a bubble.
  localparam logic [MWB_PAYLOAD_W-1:0] MWB_KILL_MASK =
      (MWB_PAYLOAD_W'(1) << MWB_WB_EN_BIT) | (MWB_PAYLOAD_W'(1) << MWB_MEM_RD_BIT);

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry: valid bit plus payload register with load and clear.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Load wins over clear; clear only drops valid so the payload stays for masking.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// flush, bubble masking of control bits and a saturating stall counter.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int unsigned          PAYLOAD_W = MWB_PAYLOAD_W,
  parameter logic [PAYLOAD_W-1:0] KILL_MASK = PAYLOAD_W'(MWB_KILL_MASK),
  parameter bit                   SKID      = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic                 main_valid, skid_valid;
  logic [PAYLOAD_W-1:0] main_data,  skid_data, main_din;
  logic                 main_load,  main_clear, skid_load, skid_clear;
  logic                 in_ready,   in_fire,    out_fire;
  logic [CNT_W-1:0]     stall_q,    stall_d;

  // With a skid entry, ready depends only on state; without it, ready looks through to downstream.
  assign in_ready = SKID ? ~skid_valid : (out_ready_i | ~main_valid);
  assign in_fire  = in_valid_i & in_ready;
  assign out_fire = main_valid & out_ready_i;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_din   = in_payload_i;
    if (flush_i) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_load  = 1'b1;
        main_din   = skid_data;
        skid_clear = 1'b1;
      end
    end else if (in_fire) begin
      if (!main_valid || out_fire) begin
        main_load = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end else if (out_fire) begin
      main_clear = 1'b1;
    end
  end

  pipe_slot #(.W(PAYLOAD_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_din),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(.W(PAYLOAD_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_payload_i),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
  end

  // Saturating count of back-pressured cycles; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready_i && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign in_ready_o    = in_ready;
  assign out_valid_o   = main_valid;
  assign out_payload_o = main_valid ? main_data : (main_data & ~KILL_MASK);
  assign occupancy_o   = occ_count(main_valid, skid_valid);
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a SKID=1/CNT_W=4 build and a SKID=0 build share the stimulus.
module tb_pipe_stage_skid_reg;

  localparam int unsigned PW = 71;
  localparam logic [PW-1:0] KM = {2'b11, 69'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [PW-1:0] in_payload = '0;

  logic          in_ready, out_valid;
  logic [PW-1:0] out_payload;
  logic [1:0]    occ;
  logic [3:0]    stall;

  logic          in_ready0, out_valid0;
  logic [PW-1:0] out_payload0;
  logic [1:0]    occ0;
  logic [15:0]   stall0;

  logic [PW-1:0] q1[$];
  logic [PW-1:0] q0[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.PAYLOAD_W(PW), .KILL_MASK(KM), .SKID(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_payload_i(in_payload),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
    .occupancy_o(occ), .stall_cnt_o(stall)
  );

  pipe_stage_skid_reg #(.PAYLOAD_W(PW), .KILL_MASK(KM), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_payload_i(in_payload),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_payload_o(out_payload0),
    .occupancy_o(occ0), .stall_cnt_o(stall0)
  );

  function automatic void chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the expected payload whenever a DUT completes an output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL skid1_unexpected_out: got %0h want none", out_payload);
        end else if (out_payload !== q1[0]) begin
          bad++;
          $display("FAIL skid1_order: got %0h want %0h", out_payload, q1[0]);
          void'(q1.pop_front());
        end else begin
          void'(q1.pop_front());
        end
      end
      if (out_valid0 && out_ready) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL skid0_unexpected_out: got %0h want none", out_payload0);
        end else if (out_payload0 !== q0[0]) begin
          bad++;
          $display("FAIL skid0_order: got %0h want %0h", out_payload0, q0[0]);
          void'(q0.pop_front());
        end else begin
          void'(q0.pop_front());
        end
      end
      chk("skid0_occ_le1", PW'(occ0 > 2'd1), '0);
      chk("skid_implies_main", PW'(dut.skid_valid & ~dut.main_valid), '0);
    end
  end

  // One cycle of stimulus: sample handshakes away from the edge, push accepted payloads at the edge.
  task automatic step();
    logic f1, f0, fl;
    @(negedge clk);
    fl = flush;
    f1 = rst_n && in_valid && in_ready && !flush;
    f0 = rst_n && in_valid && in_ready0 && !flush;
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end
    if (f1) q1.push_back(in_payload);
    if (f0) q0.push_back(in_payload);
    #1;
  endtask

  logic [PW-1:0] a, b, c1, c2;
  logic [5:0] orp;

  initial begin
    #1;
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_occ", PW'(occ), '0);
    chk("rst_stall", PW'(stall), '0);
    chk("rst_payload", out_payload, '0);
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    chk("rst_occ0", PW'(occ0), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_payload = PW'(8'h11 + i);
      step();
      chk("stream_out", out_payload, PW'(8'h11 + i));
      chk("stream_out0", out_payload0, PW'(8'h11 + i));
      chk("stream_occ", PW'(occ), PW'(1));
      chk("stream_in_ready", PW'(in_ready), PW'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", PW'(occ), '0);
    chk("stream_stall", PW'(stall), '0);

    // Back-pressure into the skid entry
    a = KM | PW'(8'hA);
    b = KM | PW'(8'hB);
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = a;
    step();
    chk("bp_occ1", PW'(occ), PW'(1));
    chk("bp_out_a", out_payload, a);
    in_payload = b;
    step();
    chk("bp_occ2", PW'(occ), PW'(2));
    chk("bp_in_ready_low", PW'(in_ready), '0);
    chk("bp_hold_a", out_payload, a);
    in_valid = 1'b0;
    step();
    chk("bp_still_a", out_payload, a);
    out_ready = 1'b1;
    step();
    chk("bp_then_b", out_payload, b);
    chk("bp_occ_after_pop", PW'(occ), PW'(1));
    step();
    chk("bp_empty", PW'(occ), '0);
    chk("bp_bubble_mask", out_payload, PW'(8'hB));
    chk("bp_stall", PW'(stall), PW'(2));

    // Flush colliding with an input
    c1 = KM | PW'(8'h31);
    c2 = KM | PW'(8'h32);
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = c1;
    step();
    in_payload = c2;
    step();
    chk("fl_occ2", PW'(occ), PW'(2));
    flush = 1'b1; in_payload = KM | PW'(8'hC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", PW'(out_valid), '0);
    chk("fl_occ", PW'(occ), '0);
    chk("fl_masked", out_payload, PW'(8'h31));
    chk("fl_in_ready", PW'(in_ready), PW'(1));
    chk("fl_stall_kept", PW'(stall), PW'(4));
    out_ready = 1'b1;
    repeat (2) step();
    chk("fl_q_empty", PW'(q1.size()), '0);

    // Stall counter saturation at 4 bits
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = PW'(8'hD1);
    step();
    in_valid = 1'b0;
    chk("sat_start", PW'(stall), PW'(4));
    repeat (10) step();
    chk("sat_14", PW'(stall), PW'(14));
    step();
    chk("sat_15", PW'(stall), PW'(15));
    repeat (9) step();
    chk("sat_hold", PW'(stall), PW'(15));
    out_ready = 1'b1;
    repeat (2) step();

    // Async reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = PW'(8'hE1);
    step();
    in_payload = PW'(8'hF1);
    step();
    chk("ar_occ2", PW'(occ), PW'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", PW'(out_valid), '0);
    chk("ar_occ", PW'(occ), '0);
    chk("ar_stall", PW'(stall), '0);
    chk("ar_payload", out_payload, '0);
    chk("ar_occ0", PW'(occ0), '0);
    q1.delete();
    q0.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ar_in_ready", PW'(in_ready), PW'(1));

    // Toggling downstream ready with continuous input
    orp = 6'b010101;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      out_ready = orp[i];
      in_payload = PW'(8'h61 + i);
      #1;
      chk("s0_in_ready_follows", PW'(in_ready0), PW'(orp[i]));
      if (i == 2) chk("s1_in_ready_registered", PW'(in_ready), '0);
      step();
      chk("s0_occ", PW'(occ0), PW'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("end_q1_empty", PW'(q1.size()), '0);
    chk("end_q0_empty", PW'(q0.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
